// File: rtl/spi_pkg.sv
// Shared SPI definitions, imported by the master controller, its shifter and
// the slave side.
//   spi_cmd_e    : 2-bit command field carried at the head of every frame.
//   spim_state_e : master controller FSM states.
//   FRAME_BITS_C : MOSI bits per frame (2-bit command + 8-bit payload).
package spi_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    WAIT,
    RECV,
    STOP
  } spim_state_e;

  localparam int FRAME_BITS_C = 10;

endpackage

// File: rtl/spim_shifter.sv
// Datapath for the SPI master: a load/shift-out register for MOSI, a
// shift-in register for MISO, and a phase bit counter with a done flag.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   load, load_data   : parallel load of the outgoing frame
//   shift_out         : shift the outgoing frame left by one bit
//   tx_msb            : current outgoing bit (frame MSB)
//   shift_in, sin     : shift one MISO bit in at the LSB
//   rx_next           : received word including the bit on sin this cycle
//   cnt_clr, cnt_en   : clear / increment the phase counter
//   cnt_last, done    : done is high while the counter equals cnt_last
module spim_shifter #(
  parameter int TX_W  = 10,
  parameter int RX_W  = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TX_W-1:0]   load_data,
  input  logic              shift_out,
  output logic              tx_msb,
  input  logic              shift_in,
  input  logic              sin,
  output logic [RX_W-1:0]   rx_next,
  input  logic              cnt_clr,
  input  logic              cnt_en,
  input  logic [CNT_W-1:0]  cnt_last,
  output logic              done
);

  logic [TX_W-1:0]  tx_q, tx_d;
  // Only RX_W-1 bits are stored: the final bit is merged straight from sin
  // into rx_next so the full word can be registered on the last sample edge.
  logic [RX_W-2:0]  rx_q, rx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tx_msb  = tx_q[TX_W-1];
  assign rx_next = {rx_q, sin};
  assign done    = (cnt_q == cnt_last);

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_d  = tx_q;
    rx_d  = rx_q;
    cnt_d = cnt_q;
    if (load)           tx_d = load_data;
    else if (shift_out) tx_d = {tx_q[TX_W-2:0], 1'b0};
    if (shift_in)       rx_d = rx_next[RX_W-2:0];
    if (cnt_clr)        cnt_d = '0;
    else if (cnt_en)    cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller. Accepts one command per valid/ready handshake and
// sends it as a 10-bit frame (cmd[1:0], payload[7:0]) MSB first on MOSI
// under ss_n, using clk as the bit clock. Read-data commands additionally
// collect an RD_BITS MISO reply after RD_TURNAROUND idle cycles and return
// it with a one-cycle rsp_valid pulse. All outputs are registered.
// Ports:
//   clk, rst             : clock (also SPI bit clock), async active-high reset
//   req_valid/req_ready  : command handshake; req_ready only in IDLE
//   req_cmd, req_data    : command and payload (payload ignored for rd_data)
//   rsp_valid, rsp_data  : read reply strobe and held reply byte
//   busy                 : FSM not in IDLE
//   ss_n, MOSI, MISO     : SPI slave select, data out, data in
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_BITS    = FRAME_BITS_C,
  parameter int RD_BITS       = 8,
  parameter int RD_TURNAROUND = 2,
  parameter int IDLE_GAP      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ss_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RD_TURNAROUND > 0) ? RD_TURNAROUND - 1 : 0);
  localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(RD_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(IDLE_GAP - 1);

  spim_state_e state_q, state_d;
  logic        rd_q, rd_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;

  logic                  load, shift_out, shift_in, cnt_clr, cnt_en, done, tx_msb;
  logic [CNT_W-1:0]      cnt_last;
  logic [RD_BITS-1:0]    rx_next;
  logic [FRAME_BITS-1:0] load_frame;
  logic                  req_is_rd;

  assign req_is_rd  = (spi_cmd_e'(req_cmd) == CMD_RD_DATA);
  assign load_frame = FRAME_BITS'({req_cmd, (req_is_rd ? 8'h00 : req_data)});

  spim_shifter #(
    .TX_W  (FRAME_BITS),
    .RX_W  (RD_BITS),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_frame),
    .shift_out (shift_out),
    .tx_msb    (tx_msb),
    .shift_in  (shift_in),
    .sin       (MISO),
    .rx_next   (rx_next),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .cnt_last  (cnt_last),
    .done      (done)
  );

  // Next state and datapath controls. The counter is cleared on every phase
  // exit so each counted phase starts from zero.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    load     = 1'b0;
    shift_in = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b1;
    cnt_last = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          load    = 1'b1;
          rd_d    = req_is_rd;
          state_d = START;
        end
      end
      START: state_d = SEND;
      SEND: begin
        cnt_en   = 1'b1;
        cnt_clr  = done;
        cnt_last = SEND_LAST;
        if (done) state_d = !rd_q ? STOP : ((RD_TURNAROUND == 0) ? RECV : WAIT);
      end
      WAIT: begin
        cnt_en   = 1'b1;
        cnt_clr  = done;
        cnt_last = WAIT_LAST;
        if (done) state_d = RECV;
      end
      RECV: begin
        shift_in = 1'b1;
        cnt_en   = 1'b1;
        cnt_clr  = done;
        cnt_last = RECV_LAST;
        if (done) state_d = STOP;
      end
      STOP: begin
        cnt_en   = 1'b1;
        cnt_clr  = done;
        cnt_last = STOP_LAST;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up
  // with the state they describe. The frame shifts as its MSB is registered
  // onto MOSI, so each SEND cycle presents the next bit.
  always_comb begin
    shift_out   = (state_d == SEND);
    ss_n_d      = (state_d inside {IDLE, STOP});
    mosi_d      = (state_d == SEND) ? tx_msb : 1'b0;
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_q == RECV) && done;
    rsp_data_d  = rsp_valid_d ? rx_next : rsp_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign ss_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
